// File: rtl/int_ctrl_pkg.sv
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared constants and FSM encoding for the interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    localparam int C_MAX_SRC = 32;
    localparam int C_ID_W    = 5;

    localparam logic [3:0] C_OFF_CTRL    = 4'h0;
    localparam logic [3:0] C_OFF_ENABLE  = 4'h4;
    localparam logic [3:0] C_OFF_PENDING = 4'h8;
    localparam logic [3:0] C_OFF_STATUS  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/int_ctrl_if.sv
// ============================================================================
//  Module      : int_ctrl_if
//  Description : Peripheral bus and core request/ack/done handshake bundle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic [31:0]       data_i;
    logic [31:0]       addr_i;
    logic              we_i;
    logic [31:0]       data_o;
    logic              int_req_o;
    logic [C_ID_W-1:0] int_id_o;
    logic              int_ack_i;
    logic              int_done_i;

    // Controller side
    modport slave (
        input  data_i, addr_i, we_i, int_ack_i, int_done_i,
        output data_o, int_req_o, int_id_o
    );

    // Bus master / core side
    modport master (
        output data_i, addr_i, we_i, int_ack_i, int_done_i,
        input  data_o, int_req_o, int_id_o
    );

endinterface

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
//  Module      : int_prio_enc
//  Description : Lowest-index find-first-set over the candidate vector.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  wire logic [N_SRC-1:0]  i_req,
    output logic                   o_valid,
    output logic [C_ID_W-1:0]      o_id
);

    // Scanning downward lets the lowest set index overwrite last.
    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = C_ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
//  Module      : int_ctrl
//  Description : Edge-triggered, lowest-index-wins interrupt controller with
//                memory-mapped CTRL/ENABLE/PENDING/STATUS registers.
//                Optional INTC_SYNC_EN adds a 2-flop input synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [N_SRC-1:0]  irq_src_i,
    int_ctrl_if.slave              bus
);

    logic [N_SRC-1:0]  w_src;
    logic [N_SRC-1:0]  r_src_q;
    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_enable;
    logic              r_ctrl_en;
    logic [N_SRC-1:0]  w_cand;
    logic [N_SRC-1:0]  w_cur_onehot;
    logic              w_cur_live;
    logic [N_SRC-1:0]  w_w1c;
    logic [N_SRC-1:0]  w_clr;
    logic              w_win_valid;
    logic [C_ID_W-1:0] w_win_id;
    logic [3:0]        w_off;
    logic              w_wr_ctrl;
    logic              w_wr_enable;
    logic              w_wr_pending;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_req;
    logic [C_ID_W-1:0] r_id;
    logic [C_ID_W-1:0] w_id_nxt;
    logic              w_ack_take;
    logic [31:0]       w_rdata;
    logic              w_unused;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0]  r_sync1;
    logic [N_SRC-1:0]  r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src_i;
`endif

    assign w_rise = w_src & ~r_src_q;

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    assign w_off        = bus.addr_i[3:0];
    assign w_wr_ctrl    = bus.we_i && (w_off == C_OFF_CTRL);
    assign w_wr_enable  = bus.we_i && (w_off == C_OFF_ENABLE);
    assign w_wr_pending = bus.we_i && (w_off == C_OFF_PENDING);
    assign w_w1c        = w_wr_pending ? bus.data_i[N_SRC-1:0] : '0;

    assign w_unused = ^{bus.addr_i[31:4], bus.data_i};

    assign w_cand       = r_pending & r_enable & {N_SRC{r_ctrl_en}};
    assign w_cur_onehot = N_SRC'(1) << r_id;
    assign w_cur_live   = |(w_cur_onehot & w_cand);

    int_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .i_req   (w_cand),
        .o_valid (w_win_valid),
        .o_id    (w_win_id)
    );

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_ack_take  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = ST_REQ;
                    w_id_nxt    = w_win_id;
                end
            end
            ST_REQ: begin
                // An ack outranks withdrawal when both happen together.
                if (bus.int_ack_i) begin
                    w_state_nxt = ST_SERVICE;
                    w_ack_take  = 1'b1;
                end else if (!w_cur_live) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.int_done_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clr = w_w1c | (w_ack_take ? w_cur_onehot : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_id      <= '0;
            r_src_q   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_ctrl_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= (w_state_nxt == ST_REQ);
            r_id      <= w_id_nxt;
            r_src_q   <= w_src;
            // New edges are ORed in after clearing so a same-cycle set wins.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_wr_ctrl) begin
                r_ctrl_en <= bus.data_i[0];
            end
            if (w_wr_enable) begin
                r_enable <= bus.data_i[N_SRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read-back
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (rst_n) begin
            case (w_off)
                C_OFF_CTRL:    w_rdata[0]         = r_ctrl_en;
                C_OFF_ENABLE:  w_rdata[N_SRC-1:0] = r_enable;
                C_OFF_PENDING: w_rdata[N_SRC-1:0] = r_pending;
                C_OFF_STATUS: begin
                    w_rdata[31] = (r_state == ST_SERVICE);
                    w_rdata[30] = r_req;
                    if (r_req || (r_state == ST_SERVICE)) begin
                        w_rdata[C_ID_W-1:0] = r_id;
                    end
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.data_o    = w_rdata;
    assign bus.int_req_o = r_req;
    assign bus.int_id_o  = r_id;

endmodule

`default_nettype wire
